// File: rtl/pixel_seq_pkg.sv
// Shared types and pixel transforms for the pixel operation sequencer.
package pixel_seq_pkg;

   localparam int unsigned PIX_W = 24;

   typedef enum logic [1:0] {
      OpFill   = 2'b00,
      OpInvert = 2'b01,
      OpGray   = 2'b10,
      OpRsvd   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StPrime,
      StStream,
      StDrain,
      StDone
   } state_e;

   function automatic logic [PIX_W-1:0] invert24(input logic [PIX_W-1:0] pix);
      return ~pix;
   endfunction

   // R+G+B never exceeds 765, so the quotient always fits in 8 bits.
   function automatic logic [PIX_W-1:0] gray24(input logic [PIX_W-1:0] pix);
      logic [9:0] sum;
      logic [9:0] quo;
      sum = 10'(pix[23:16]) + 10'(pix[15:8]) + 10'(pix[7:0]);
      quo = sum / 10'd3;
      return {quo[7:0], quo[7:0], quo[7:0]};
   endfunction

endpackage

// File: rtl/pixel_op_sequencer_if.sv
// Command handshake, status and frame-buffer RAM bus of the pixel sequencer.
// master: host/RAM side; slave: the sequencer.
interface pixel_op_sequencer_if
   import pixel_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 4
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [PIX_W-1:0]  cmd_color;
   logic              abort;
   logic              busy;
   logic              done;
   logic              cmd_err;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;
   logic [31:0]       checksum;

   modport master (
      output cmd_valid, cmd_op, cmd_color, abort, rd_data,
      input  cmd_ready, busy, done, cmd_err, rd_en, rd_addr, wr_en, wr_addr, wr_data, checksum
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_color, abort, rd_data,
      output cmd_ready, busy, done, cmd_err, rd_en, rd_addr, wr_en, wr_addr, wr_data, checksum
   );
endinterface

// File: rtl/pixel_alu.sv
// Combinational per-pixel transform applied to streamed read data.
module pixel_alu
   import pixel_seq_pkg::*;
(
   input  op_e              op_i,
   input  logic [PIX_W-1:0] pix_i,
   output logic [PIX_W-1:0] pix_o
);

   // Select the transform for the latched operation.
   always_comb begin
      pix_o = pix_i;
      unique case (op_i)
         OpInvert: pix_o = invert24(pix_i);
         OpGray:   pix_o = gray24(pix_i);
         default:  pix_o = pix_i;
      endcase
   end

endmodule

// File: rtl/pixel_op_sequencer.sv
// Whole-image pixel operation sequencer over an external simple-dual-port RAM.
// Optional running checksum of written pixels: define PIXEL_SEQ_CHECKSUM_EN.
module pixel_op_sequencer
   import pixel_seq_pkg::*;
#(
   parameter int unsigned W      = 4,
   parameter int unsigned H      = 3,
   parameter int unsigned ADDR_W = (W * H > 1) ? $clog2(W * H) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pixel_op_sequencer_if.slave  bus
);

   localparam int unsigned      N        = W * H;
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N - 1);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [PIX_W-1:0]  color_q, color_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic              rd_en, wr_en;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [PIX_W-1:0]  wr_data, alu_pix;
   logic              accept;

   pixel_alu u_alu (
      .op_i  (op_q),
      .pix_i (bus.rd_data),
      .pix_o (alu_pix)
   );

   assign accept = (state_q == StIdle) && bus.cmd_valid;

   // Next-state: command latch, address walk and abort handling.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      color_d = color_q;
      err_d   = err_q;
      addr_d  = addr_q;
      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               op_d    = op_e'(bus.cmd_op);
               color_d = bus.cmd_color;
               addr_d  = '0;
               err_d   = 1'b0;
               unique case (op_e'(bus.cmd_op))
                  OpFill:           state_d = StFill;
                  OpInvert, OpGray: state_d = StPrime;
                  default: begin
                     err_d   = 1'b1;
                     state_d = StDone;
                  end
               endcase
            end
         end
         StFill: begin
            if (addr_q == LastAddr) state_d = StDone;
            else                    addr_d  = addr_q + ADDR_W'(1);
         end
         StPrime: begin
            if (N == 1) begin
               state_d = StDrain;
            end else begin
               addr_d  = ADDR_W'(1);
               state_d = StStream;
            end
         end
         StStream: begin
            if (addr_q == LastAddr) state_d = StDrain;
            else                    addr_d  = addr_q + ADDR_W'(1);
         end
         StDrain: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (state_q != StIdle && bus.abort) state_d = StIdle;
   end

   // State and command registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= OpFill;
         color_q <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         color_q <= color_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
      end
   end

   // RAM strobes decoded from state; writes trail reads by one address.
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      unique case (state_q)
         StFill: begin
            wr_en   = 1'b1;
            wr_addr = addr_q;
            wr_data = color_q;
         end
         StPrime: begin
            rd_en   = 1'b1;
            rd_addr = addr_q;
         end
         StStream: begin
            rd_en   = 1'b1;
            rd_addr = addr_q;
            wr_en   = 1'b1;
            wr_addr = addr_q - ADDR_W'(1);
            wr_data = alu_pix;
         end
         StDrain: begin
            wr_en   = 1'b1;
            wr_addr = addr_q;
            wr_data = alu_pix;
         end
         default: ;
      endcase
   end

   assign bus.cmd_ready = (state_q == StIdle);
   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = (state_q == StDone);
   assign bus.cmd_err   = (state_q == StDone) && err_q;
   assign bus.rd_en     = rd_en;
   assign bus.rd_addr   = rd_addr;
   assign bus.wr_en     = wr_en;
   assign bus.wr_addr   = wr_addr;
   assign bus.wr_data   = wr_data;

`ifdef PIXEL_SEQ_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   // Running sum of written pixels, restarted by each accepted command.
   always_comb begin
      checksum_d = checksum_q;
      if (accept)     checksum_d = '0;
      else if (wr_en) checksum_d = checksum_q + 32'(wr_data);
   end

   // Checksum register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) checksum_q <= '0;
      else        checksum_q <= checksum_d;
   end

   assign bus.checksum = checksum_q;
`else
   assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_pixel_op_sequencer.sv
// Self-checking bench for pixel_op_sequencer: vector table plus corner sequences,
// write scoreboard fed from a bench-side image model.
module tb_pixel_op_sequencer;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int N  = W * H;
   localparam int AW = 4;

   typedef struct {
      logic [1:0]  op;
      logic [23:0] color;
      logic [23:0] pre;
      bit          gpat;
      int          lat;
      bit          err;
      string       nm;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [23:0]   data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pixel_op_sequencer_if #(.ADDR_W(AW)) bus ();

   pixel_op_sequencer #(.W(W), .H(H), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [23:0] mem     [N];
   logic [23:0] pre_pat [N];
   logic [23:0] img     [N];
   logic        pre_en;

   // Frame-buffer RAM model: registered read, one-cycle latency.
   always @(posedge clk) begin
      if (pre_en) begin
         for (int i = 0; i < N; i++) mem[i] <= pre_pat[i];
      end else if (bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
   end

   wr_t         exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          rd_cnt   = 0;
   logic [31:0] exp_sum  = '0;
   vec_t        vecs [5];

   function automatic logic [23:0] model_gray(input logic [23:0] p);
      int          s;
      int          g;
      logic [7:0]  gb;
      s  = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
      g  = s / 3;
      gb = g[7:0];
      return {gb, gb, gb};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // One cycle: sample at the falling edge and score any write.
   task automatic tick();
      wr_t e;
      @(negedge clk);
      if (bus.rd_en) rd_cnt++;
      if (bus.wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h@%0h required=none", bus.wr_data,
                     bus.wr_addr);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
            check("wr_data", 64'(bus.wr_data), 64'(e.data));
         end
      end
   endtask

   task automatic preload(input logic [23:0] uni, input bit gpat);
      logic [23:0] glist [3];
      glist[0] = 24'h102030;
      glist[1] = 24'hFF0000;
      glist[2] = 24'hFFFFFF;
      for (int i = 0; i < N; i++) begin
         pre_pat[i] = gpat ? glist[i % 3] : uni;
         img[i]     = pre_pat[i];
      end
      pre_en = 1'b1;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic push_writes(input logic [1:0] op, input logic [23:0] color, input int cnt);
      wr_t e;
      for (int i = 0; i < cnt; i++) begin
         e.addr = AW'(i);
         case (op)
            2'b00:   e.data = color;
            2'b01:   e.data = ~img[i];
            default: e.data = model_gray(img[i]);
         endcase
         exp_q.push_back(e);
         exp_sum = exp_sum + 32'(e.data);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [23:0] color);
      bus.cmd_op    = op;
      bus.cmd_color = color;
      bus.cmd_valid = 1'b1;
   endtask

   // Runs from the accept edge up to and including the done cycle.
   task automatic wait_done(input int exp_lat, input bit exp_err, input bit hold,
                            input string nm);
      int          rel;
      bit          got;
      bit          viol;
      logic        err_seen;
      logic [31:0] cs_seen;
      logic [31:0] cs_req;
      rel = 0; got = 0; viol = 0; err_seen = 0; cs_seen = '0;
      while (rel < 40 && !got) begin
         tick();
         rel++;
         if (rel == 1 && !hold) bus.cmd_valid = 1'b0;
         if (!(bus.busy && !bus.cmd_ready)) viol = 1;
         if (bus.done) begin
            got      = 1;
            err_seen = bus.cmd_err;
            cs_seen  = bus.checksum;
         end
      end
      check({nm, "_done_seen"}, 64'(got), 64'd1);
      check({nm, "_done_latency"}, 64'(rel), 64'(exp_lat));
      check({nm, "_cmd_err"}, 64'(err_seen), 64'(exp_err));
      check({nm, "_busy_span"}, 64'(viol), 64'd0);
`ifdef PIXEL_SEQ_CHECKSUM_EN
      cs_req = exp_sum;
`else
      cs_req = '0;
`endif
      check({nm, "_checksum"}, 64'(cs_seen), 64'(cs_req));
   endtask

   initial begin
      int   rd0;
      bit   bad;
      rst_n         = 1'b0;
      pre_en        = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_color = '0;
      bus.abort     = 1'b0;
      bus.rd_data   = '0;

      vecs[0] = '{2'b00, 24'h123456, 24'h000000, 1'b0, 13, 1'b0, "fill"};
      vecs[1] = '{2'b01, 24'h000000, 24'h00FF10, 1'b0, 14, 1'b0, "invert"};
      vecs[2] = '{2'b10, 24'h000000, 24'h000000, 1'b1, 14, 1'b0, "gray"};
      vecs[3] = '{2'b01, 24'h000000, 24'h000000, 1'b1, 14, 1'b0, "invert_mix"};
      vecs[4] = '{2'b11, 24'hABCDEF, 24'h777777, 1'b0, 1,  1'b1, "reserved"};

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("reset_flags", 64'({bus.cmd_ready, bus.busy, bus.done, bus.cmd_err, bus.rd_en,
                                bus.wr_en}), 64'b100000);
      check("reset_bus", 64'({bus.rd_addr, bus.wr_addr, bus.wr_data}), 64'd0);
      check("reset_checksum", 64'(bus.checksum), 64'd0);

      // Table-driven commands.
      for (int v = 0; v < 5; v++) begin
         preload(vecs[v].pre, vecs[v].gpat);
         exp_sum = '0;
         rd0     = rd_cnt;
         if (vecs[v].op != 2'b11) push_writes(vecs[v].op, vecs[v].color, N);
         issue(vecs[v].op, vecs[v].color);
         wait_done(vecs[v].lat, vecs[v].err, 1'b0, vecs[v].nm);
         tick();
         check({vecs[v].nm, "_ready_after"}, 64'(bus.cmd_ready), 64'd1);
         check({vecs[v].nm, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
         if (vecs[v].op == 2'b11) check("reserved_reads", 64'(rd_cnt - rd0), 64'd0);
      end

      // cmd_valid held through a FILL with another colour: taken right after done.
      preload(24'h0, 1'b0);
      exp_sum = '0;
      push_writes(2'b00, 24'h111111, N);
      issue(2'b00, 24'h111111);
      tick();
      bus.cmd_color = 24'h222222;
      check("hold_first_busy", 64'({bus.busy, bus.cmd_ready}), 64'b10);
      begin
         int  rel;
         bit  got;
         rel = 1; got = 0;
         while (rel < 40 && !got) begin
            tick();
            rel++;
            if (bus.cmd_ready) got = 1;
         end
         // Ready reappears one cycle after the done cycle.
         check("hold_ready_return", 64'(rel), 64'd14);
      end
      exp_sum = '0;
      push_writes(2'b00, 24'h222222, N);
      wait_done(13, 1'b0, 1'b0, "hold_second");
      tick();
      check("hold_pending_writes", 64'(exp_q.size()), 64'd0);

      // Abort in the fifth STREAM cycle: five writes, then silence.
      preload(24'h00FF10, 1'b0);
      push_writes(2'b01, 24'h0, 5);
      issue(2'b01, 24'h0);
      tick();
      bus.cmd_valid = 1'b0;
      repeat (5) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_idle", 64'({bus.cmd_ready, bus.busy, bus.done, bus.wr_en, bus.rd_en}),
            64'b10000);
      rd0 = rd_cnt;
      bad = 0;
      repeat (16) begin
         tick();
         if (bus.done || bus.busy) bad = 1;
      end
      check("abort_no_done", 64'(bad), 64'd0);
      check("abort_no_reads", 64'(rd_cnt - rd0), 64'd0);
      check("abort_pending_writes", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of a FILL, then a reserved op.
      exp_sum = '0;
      push_writes(2'b00, 24'hABCDEF, 4);
      issue(2'b00, 24'hABCDEF);
      tick();
      bus.cmd_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_flags", 64'({bus.cmd_ready, bus.busy, bus.done, bus.cmd_err, bus.rd_en,
                                 bus.wr_en}), 64'b100000);
      check("midrst_bus", 64'({bus.wr_addr, bus.wr_data, bus.checksum}), 64'd0);
      check("midrst_pending_writes", 64'(exp_q.size()), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      exp_sum = '0;
      rd0     = rd_cnt;
      issue(2'b11, 24'h55AA55);
      wait_done(1, 1'b1, 1'b0, "rsvd_after_rst");
      tick();
      check("rsvd_after_rst_reads", 64'(rd_cnt - rd0), 64'd0);
      check("rsvd_after_rst_ready", 64'(bus.cmd_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pixel_op_sequencer.md
# pixel_op_sequencer

Sequencer that applies whole-image pixel operations (fill, invert, grayscale) to a W×H RGB frame buffer held in an external simple-dual-port RAM. It accepts one command at a time over a valid/ready handshake and walks the buffer in row-major order at one pixel per clock. It sits between the control path (testbench or host FSM) and the frame-buffer RAM, and owns that RAM's ports while busy.

## Interface
- `W`, 4, image width in pixels
- `H`, 3, image height in pixels
- `ADDR_W`, `$clog2(W*H)`, linear pixel address width (addr = y*W + x)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer idle and able to accept
- `cmd_op`  in  2  00 FILL, 01 INVERT, 10 GRAY, 11 reserved
- `cmd_color`  in  24  fill colour 0xRRGGBB (FILL only)
- `abort`  in  1  cancel the running command
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse on completion
- `cmd_err`  out  1  one-cycle pulse with `done` for a reserved op
- `rd_en`  out  1  RAM read strobe
- `rd_addr`  out  ADDR_W  RAM read address
- `rd_data`  in  24  RAM read data, valid exactly 1 cycle after `rd_en`
- `wr_en`  out  1  RAM write strobe
- `wr_addr`  out  ADDR_W  RAM write address
- `wr_data`  out  24  RAM write data
- `checksum`  out  32  running sum of written pixels (see Configuration)

## Operation
- States: IDLE, FILL, PRIME, STREAM, DRAIN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch op and colour, reset address counters to 0. FILL→FILL; INVERT/GRAY→PRIME; reserved→DONE with `cmd_err`.
- FILL: write `cmd_color` to addr 0..N-1 (N=W*H), one per cycle; after addr N-1 → DONE.
- PRIME: read addr 0. N=1 → DRAIN, else → STREAM.
- STREAM: each cycle write transform(`rd_data`) to addr k-1 and read addr k; after reading N-1 → DRAIN.
- DRAIN: write transform of pixel N-1, no read → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- INVERT: per-channel bitwise NOT. GRAY: sum = R+G+B in 10 bits, g = sum/3 (truncating, max 255), output {g,g,g}.
- `abort` in any non-IDLE state: next state IDLE, no further `rd_en`/`wr_en`, no `done`. Ignored in IDLE.
- `cmd_valid` while busy is not accepted; command inputs are don't-care outside the accept cycle.
- Write address always lags read address by one, so read and write never target the same address in the same cycle.

## Timing
- Reset: state IDLE, `cmd_ready`=1, `busy`/`done`/`cmd_err`/`rd_en`/`wr_en`=0, addresses, `wr_data` and `checksum`=0. Reset mid-command abandons it immediately with no further RAM access.
- All outputs are registered or decoded from state alone; none depend combinationally on `cmd_valid`.
- Accept at cycle t: FILL writes at t+1..t+N, `done` at t+N+1. INVERT/GRAY: PRIME at t+1, writes at t+2..t+N+1, `done` at t+N+2. Reserved op: `done`+`cmd_err` at t+1.
- `busy` = 1 from t+1 through the DONE cycle inclusive. `cmd_ready` = 0 over the same span and returns to 1 the cycle after DONE.

## Configuration
- `PIXEL_SEQ_CHECKSUM_EN` defined: `checksum` cleared on command accept and increments by the zero-extended `wr_data` on every `wr_en` cycle, mod 2^32; it holds its value after completion.
- Not defined: `checksum` tied to 0 and the adder is not synthesised.

## Structure
- `pixel_seq_pkg`: op enum, state enum, `PIX_W`=24, and pure functions `invert24` and `gray24`.
- One sub-module, `pixel_alu`: combinational op×24-bit → 24-bit transform used in STREAM/DRAIN.

## Test plan
- W=4, H=3, FILL 0x123456 → `wr_en` on 12 consecutive cycles, addr 0..11, data 0x123456; `done` at t+13; `checksum` = 12×0x123456 when enabled.
- RAM preloaded 0x00FF10 everywhere, INVERT → 12 writes of 0xFFFF00EF masked to 24 bits (0xFF00EF); first write at t+2 to addr 0, `done` at t+14.
- GRAY on pixels 0x102030, 0xFF0000, 0xFFFFFF → writes 0x202020, 0x555555, 0xFFFFFF.
- `cmd_valid` held high during a FILL with a different colour → `cmd_ready`=0, command ignored, no extra writes; it is accepted the cycle after `done`.
- `abort` during STREAM cycle 5 → no `wr_en` from the next cycle, IDLE, no `done`, `cmd_ready`=1 the next cycle.
- `rst_n` low mid-FILL → outputs at reset values immediately; reserved op afterwards → `done`+`cmd_err` at t+1 with no RAM access.
